// File: rtl/cpu_status_reg_pkg.sv
// Shared definitions for the CPU status stage: P register bit positions,
// reset value and the helper that forces the fixed P bits.
package cpu_status_reg_pkg;

  localparam logic [2:0] FLAG_C = 3'd0;
  localparam logic [2:0] FLAG_Z = 3'd1;
  localparam logic [2:0] FLAG_I = 3'd2;
  localparam logic [2:0] FLAG_D = 3'd3;
  localparam logic [2:0] FLAG_B = 3'd4;
  localparam logic [2:0] FLAG_U = 3'd5;
  localparam logic [2:0] FLAG_V = 3'd6;
  localparam logic [2:0] FLAG_N = 3'd7;

  localparam logic [7:0] P_RESET_DEF = 8'h24;

  // Bit5 always reads 1 and B is never stored; it exists only in the push image.
  function automatic logic [7:0] fix_p_bits(input logic [7:0] p);
    logic [7:0] r;
    r         = p;
    r[FLAG_U] = 1'b1;
    r[FLAG_B] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/cpu_status_reg_flag_calc.sv
// Combinational N/Z/C/V derivation from ALU operands, operation and result.
// Shared with the future BCD adjust stage, so it holds no state.
module cpu_flag_calc
  import cpu_status_reg_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] out,
  input  logic       op_add,
  input  logic       op_sub,
  output logic       n_s,
  output logic       z_s,
  output logic       c_s,
  output logic       v_s,
  output logic       cv_valid_s
);

  logic [8:0] sum_s;

  assign sum_s = {1'b0, b} + {1'b0, a};

  // Flag derivation; add wins over sub when both are (erroneously) asserted.
  always_comb begin
    n_s        = out[7];
    z_s        = (out == 8'h00);
    c_s        = 1'b0;
    v_s        = 1'b0;
    cv_valid_s = 1'b0;
    if (op_add) begin
      c_s        = sum_s[8];
      v_s        = ~(a[7] ^ b[7]) & (a[7] ^ out[7]);
      cv_valid_s = 1'b1;
    end else if (op_sub) begin
      c_s        = (b >= a);
      v_s        = (b[7] ^ a[7]) & (b[7] ^ out[7]);
      cv_valid_s = 1'b1;
    end else begin
      c_s        = 1'b0;
      v_s        = 1'b0;
      cv_valid_s = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_status_reg.sv
// ALU result register and 6502 P register with prioritised flag merge
// (PLP/RTI load > SEx/CLx > BIT > ALU updates) and the PHP/BRK push image.
module cpu_status_reg
  import cpu_status_reg_pkg::*;
#(
  parameter logic [7:0] P_RESET = P_RESET_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       op_add,
  input  logic       op_sub,
  input  logic       op_inc,
  input  logic       latch_res,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_test,
  input  logic       flag_we,
  input  logic [2:0] flag_sel,
  input  logic       flag_val,
  input  logic       p_load,
  input  logic [7:0] p_in,
  input  logic       brk_push,
  output logic [7:0] res_q,
  output logic [7:0] p_q,
  output logic [7:0] p_push
);

  logic       n_s;
  logic       z_s;
  logic       c_s;
  logic       v_s;
  logic       cv_valid_s;
  logic       op_inc_unused_s;
  logic       flag_wr_s;
  logic [7:0] alu_p_s;
  logic [7:0] flag_mask_s;
  logic [7:0] flag_bits_s;
  logic [7:0] p_next_s;
  logic [7:0] res_next_s;

  // op_inc only affects N/Z through alu_out, never C or V.
  assign op_inc_unused_s = op_inc;

  cpu_flag_calc u_flag_calc (
    .a          (alu_a),
    .b          (alu_b),
    .out        (alu_out),
    .op_add     (op_add),
    .op_sub     (op_sub),
    .n_s        (n_s),
    .z_s        (z_s),
    .c_s        (c_s),
    .v_s        (v_s),
    .cv_valid_s (cv_valid_s)
  );

  assign flag_wr_s   = flag_we & (flag_sel != FLAG_B) & (flag_sel != FLAG_U);
  assign flag_mask_s = 8'h01 << flag_sel;
  assign flag_bits_s = {7'b000_0000, flag_val} << flag_sel;

  // ALU-sourced flags: BIT overrides upd_nz/upd_v, C only moves on add/sub.
  always_comb begin
    alu_p_s         = p_q;
    alu_p_s[FLAG_N] = bit_test ? alu_b[7] : (upd_nz ? n_s : p_q[FLAG_N]);
    alu_p_s[FLAG_Z] = bit_test ? ((alu_a & alu_b) == 8'h00) : (upd_nz ? z_s : p_q[FLAG_Z]);
    alu_p_s[FLAG_V] = bit_test ? alu_b[6] : ((upd_v & cv_valid_s) ? v_s : p_q[FLAG_V]);
    alu_p_s[FLAG_C] = (upd_c & cv_valid_s) ? c_s : p_q[FLAG_C];
  end

  // Next-state merge for both registers.
  always_comb begin
    res_next_s = res_q;
    p_next_s   = p_q;
    if (latch_res) begin
      res_next_s = alu_out;
    end else begin
      res_next_s = res_q;
    end
    if (p_load) begin
      p_next_s = fix_p_bits(p_in);
    end else if (flag_wr_s) begin
      p_next_s = fix_p_bits((alu_p_s & ~flag_mask_s) | flag_bits_s);
    end else begin
      p_next_s = fix_p_bits(alu_p_s);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= 8'h00;
      p_q   <= P_RESET;
    end else begin
      res_q <= res_next_s;
      p_q   <= p_next_s;
    end
  end

  assign p_push = {p_q[7:6], 1'b1, brk_push, p_q[3:0]};

endmodule

// File: tb/tb_cpu_status_reg.sv
// Directed table-driven bench for cpu_status_reg with hand-computed expectations,
// plus hand-written sequences for async reset and the combinational push image.
module tb_cpu_status_reg;

  logic       clk;
  logic       rst;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       op_add, op_sub, op_inc;
  logic       latch_res, upd_nz, upd_c, upd_v, bit_test;
  logic       flag_we;
  logic [2:0] flag_sel;
  logic       flag_val;
  logic       p_load;
  logic [7:0] p_in;
  logic       brk_push;
  logic [7:0] res_q, p_q, p_push;

  int errors = 0;
  int checks = 0;

  cpu_status_reg dut (
    .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .op_add(op_add), .op_sub(op_sub), .op_inc(op_inc), .latch_res(latch_res),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_test(bit_test),
    .flag_we(flag_we), .flag_sel(flag_sel), .flag_val(flag_val),
    .p_load(p_load), .p_in(p_in), .brk_push(brk_push),
    .res_q(res_q), .p_q(p_q), .p_push(p_push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, o;
    logic [2:0] op;   // {add, sub, inc}
    logic [3:0] upd;  // {latch_res, upd_nz, upd_c, upd_v}
    logic       bt, fwe;
    logic [2:0] fsel;
    logic       fval, pload;
    logic [7:0] pin;
    logic       brk;
    logic [7:0] exp_res, exp_p, exp_push;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [7:0] a, b, o, input logic [2:0] op,
                              input logic [3:0] upd, input logic bt, fwe,
                              input logic [2:0] fsel, input logic fval, pload,
                              input logic [7:0] pin, input logic brk,
                              input logic [7:0] er, ep, epu);
    vec_t v;
    v.a = a; v.b = b; v.o = o; v.op = op; v.upd = upd; v.bt = bt; v.fwe = fwe;
    v.fsel = fsel; v.fval = fval; v.pload = pload; v.pin = pin; v.brk = brk;
    v.exp_res = er; v.exp_p = ep; v.exp_push = epu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_a = 8'h00; alu_b = 8'h00; alu_out = 8'h00;
    op_add = 1'b0; op_sub = 1'b0; op_inc = 1'b0;
    latch_res = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; bit_test = 1'b0;
    flag_we = 1'b0; flag_sel = 3'd0; flag_val = 1'b0;
    p_load = 1'b0; p_in = 8'h00; brk_push = 1'b0;
  endtask

  initial begin
    //            a      b      out    op      upd      bt   fwe  sel   val  pld  pin    brk   res    p      push
    vecs[0]  = mk(8'h50, 8'h50, 8'hA0, 3'b100, 4'b1111, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 8'hE4, 8'hE4);
    vecs[1]  = mk(8'h01, 8'h00, 8'hFF, 3'b010, 4'b0110, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 8'hE4, 8'hE4);
    vecs[2]  = mk(8'h10, 8'h10, 8'h00, 3'b010, 4'b0110, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 8'h67, 8'h67);
    vecs[3]  = mk(8'hFF, 8'h00, 8'h00, 3'b001, 4'b0110, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 8'h67, 8'h67);
    vecs[4]  = mk(8'h01, 8'hC0, 8'h05, 3'b000, 4'b0100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 8'hE7, 8'hE7);
    vecs[5]  = mk(8'h00, 8'h00, 8'h3C, 3'b000, 4'b1000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h3C, 8'hEF, 8'hFF);
    vecs[6]  = mk(8'h00, 8'h00, 8'h00, 3'b000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'hEF, 8'hEF);
    vecs[7]  = mk(8'h00, 8'h00, 8'h00, 3'b000, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'hEE, 8'hEE);
    vecs[8]  = mk(8'h01, 8'h01, 8'h02, 3'b100, 4'b0110, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h6D, 8'h6D);
    vecs[9]  = mk(8'h00, 8'h00, 8'h00, 3'b000, 4'b0000, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h6D, 8'h6D);
    vecs[10] = mk(8'h00, 8'h00, 8'h00, 3'b000, 4'b0000, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h6D, 8'h6D);
    vecs[11] = mk(8'h50, 8'h50, 8'hA0, 3'b100, 4'b0001, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h2D, 8'h2D);
    vecs[12] = mk(8'hFF, 8'hFF, 8'h00, 3'b000, 4'b0011, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h2D, 8'h2D);
    vecs[13] = mk(8'h05, 8'h80, 8'h7B, 3'b010, 4'b1111, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h7B, 8'h6D, 8'h6D);
    vecs[14] = mk(8'hFF, 8'h02, 8'h01, 3'b100, 4'b1111, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h2D, 8'h2D);
    vecs[15] = mk(8'h01, 8'h01, 8'h02, 3'b110, 4'b0010, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h2C, 8'h2C);
    vecs[16] = mk(8'h00, 8'h00, 8'h00, 3'b000, 4'b0000, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h24, 8'h24);
    vecs[17] = mk(8'h00, 8'h00, 8'h00, 3'b000, 4'b0100, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 8'h20, 8'h20);
    vecs[18] = mk(8'h7F, 8'h00, 8'h80, 3'b001, 4'b0111, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'hA0, 8'hA0);

    idle_inputs();
    rst = 1'b1;
    #1;
    chk("reset res_q", res_q, 8'h00);
    chk("reset p_q", p_q, 8'h24);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      alu_a = vecs[i].a; alu_b = vecs[i].b; alu_out = vecs[i].o;
      {op_add, op_sub, op_inc} = vecs[i].op;
      {latch_res, upd_nz, upd_c, upd_v} = vecs[i].upd;
      bit_test = vecs[i].bt; flag_we = vecs[i].fwe; flag_sel = vecs[i].fsel;
      flag_val = vecs[i].fval; p_load = vecs[i].pload; p_in = vecs[i].pin;
      brk_push = vecs[i].brk;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d res_q", i), res_q, vecs[i].exp_res);
      chk($sformatf("v%0d p_q", i), p_q, vecs[i].exp_p);
      chk($sformatf("v%0d p_push", i), p_push, vecs[i].exp_push);
    end

    // Push image follows brk_push without a clock edge.
    idle_inputs();
    brk_push = 1'b1;
    #1;
    chk("push brk=1", p_push, 8'hB0);
    brk_push = 1'b0;
    #1;
    chk("push brk=0", p_push, 8'hA0);

    // Async reset mid-cycle while strobes are active.
    @(negedge clk);
    latch_res = 1'b1; upd_nz = 1'b1; alu_out = 8'h80;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst res_q", res_q, 8'h00);
    chk("async rst p_q", p_q, 8'h24);
    @(posedge clk);
    #1;
    chk("rst held res_q", res_q, 8'h00);
    chk("rst held p_q", p_q, 8'h24);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("post rst res_q", res_q, 8'h00);
    chk("post rst p_q", p_q, 8'h24);
    latch_res = 1'b1; alu_out = 8'h55;
    @(posedge clk);
    #1;
    chk("post rst latch", res_q, 8'h55);
    chk("post rst latch p_q", p_q, 8'h24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
